// File: rtl/addsub_result_stage_pkg.sv
// Shared definitions for the adder/subtractor result stage: flag layout,
// saturation limits and the buffered entry format.
package addsub_result_stage_pkg;

    localparam int DATA_W = 32;

    // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Signed extremes used when clamping an overflowed result.
    localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

    typedef logic [3:0] flags_t;

    // One buffered result with its flags.
    typedef struct packed {
        logic [DATA_W-1:0] result;
        flags_t            flags;
    } entry_t;

endpackage

// File: rtl/addsub_flag_calc.sv
// Combinational flag generation and optional signed saturation for one
// adder/subtractor result.
module addsub_flag_calc
    import addsub_result_stage_pkg::*;
#(
    parameter int SAT = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    input  logic [DATA_W-1:0] sum,
    input  logic              cout,
    output logic [DATA_W-1:0] result,
    output flags_t            flags
);

    logic beff_msb;
    logic ovf;

    // Only the operand sign bits feed the overflow logic; the remaining
    // operand bits are already reflected in the adder's sum.
    logic unused_operand_lsbs;
    assign unused_operand_lsbs = ^{a[DATA_W-2:0], b[DATA_W-2:0]};

    // Clamp to the signed extreme matching the sign of operand a.
    function automatic logic [DATA_W-1:0] saturate(
        input logic [DATA_W-1:0] sum_v,
        input logic              a_sign,
        input logic              ovf_v
    );
        if ((SAT != 0) && ovf_v) begin
            return a_sign ? SAT_MIN : SAT_MAX;
        end
        return sum_v;
    endfunction

    // Overflow from operand signs, then N/Z from the final (possibly clamped) result.
    always_comb begin
        beff_msb = b[DATA_W-1] ^ sub;
        ovf      = (a[DATA_W-1] == beff_msb) && (sum[DATA_W-1] != a[DATA_W-1]);
        result   = saturate(sum, a[DATA_W-1], ovf);
        flags         = '0;
        flags[FLAG_N] = result[DATA_W-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = cout;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/addsub_result_stage.sv
// Result stage behind the 32-bit adder/subtractor: captures sum/carry with
// their operands, derives flags, buffers results in a small FIFO with a
// valid/ready output, and tracks a sticky overflow flag and an op counter.
module addsub_result_stage
    import addsub_result_stage_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int SAT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_sub,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_flags,
    output logic              sticky_v,
    input  logic              clr_sticky,
    output logic [15:0]       op_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] calc_result;
    flags_t            calc_flags;
    entry_t            new_entry;

    entry_t            mem_q [DEPTH];
    entry_t            head_q, head_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sticky_q, sticky_d;
    logic [15:0]       op_count_q, op_count_d;
    logic              push, pop;

    addsub_flag_calc #(
        .SAT (SAT)
    ) u_flag_calc (
        .a      (in_a),
        .b      (in_b),
        .sub    (in_sub),
        .sum    (in_sum),
        .cout   (in_cout),
        .result (calc_result),
        .flags  (calc_flags)
    );

    assign new_entry.result = calc_result;
    assign new_entry.flags  = calc_flags;

    // Readiness depends only on stored occupancy, and is forced low in reset.
    assign in_ready  = !rst && (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_result = head_q.result;
    assign out_flags  = head_q.flags;
    assign sticky_v   = sticky_q;
    assign op_count   = op_count_q;

    // Next-state for pointers, occupancy, the registered head entry and counters.
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
        head_d     = head_q;
        sticky_d   = (sticky_q && !clr_sticky) || (push && calc_flags[FLAG_V]);
        op_count_d = op_count_q;

        if (push) begin
            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            op_count_d = op_count_q + 16'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_nxt;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The head register shows the oldest entry. A new entry goes straight
        // to the head when the buffer is empty, or when the only stored entry
        // is popped in the same cycle. Popping the last entry leaves the head
        // holding its previous value.
        if (push && ((count_q == '0) || (pop && (rd_ptr_nxt == wr_ptr_q)))) begin
            head_d = new_entry;
        end else if (pop && (count_q > CNT_W'(1))) begin
            head_d = mem_q[rd_ptr_nxt];
        end
    end

    // Entry storage; contents are only meaningful where tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // Control and visible state; reset discards every buffered entry at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            head_q     <= '0;
            sticky_q   <= 1'b0;
            op_count_q <= '0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            head_q     <= head_d;
            sticky_q   <= sticky_d;
            op_count_q <= op_count_d;
        end
    end

endmodule

// File: tb/tb_addsub_result_stage.sv
// Directed bench for addsub_result_stage: a SAT=0 and a SAT=1 instance share
// the same stimulus; table vectors cover flag/saturation math, followed by
// hand-written sequences for buffering, sticky flag, reset and counter wrap.
module tb_addsub_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic [31:0] in_sum;
    logic        in_cout;
    logic        out_ready;
    logic        clr_sticky;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [31:0] out_result0, out_result1;
    logic [3:0]  out_flags0, out_flags1;
    logic        sticky0, sticky1;
    logic [15:0] op_count0, op_count1;

    int checks = 0;
    int errors = 0;

    addsub_result_stage #(.DEPTH(2), .SAT(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .out_result (out_result0),
        .out_flags  (out_flags0),
        .sticky_v   (sticky0),
        .clr_sticky (clr_sticky),
        .op_count   (op_count0)
    );

    addsub_result_stage #(.DEPTH(2), .SAT(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready1),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .out_valid  (out_valid1),
        .out_ready  (out_ready),
        .out_result (out_result1),
        .out_flags  (out_flags1),
        .sticky_v   (sticky1),
        .clr_sticky (clr_sticky),
        .op_count   (op_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic [31:0] res0;
        logic [3:0]  fl0;
        logic [31:0] res1;
        logic [3:0]  fl1;
        logic        sticky;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            input logic [31:0] sum, input logic cout);
        in_a    = a;
        in_b    = b;
        in_sub  = sub;
        in_sum  = sum;
        in_cout = cout;
    endtask

    initial begin
        //            a             b             sub  sum           cout res0          fl0      res1          fl1      sticky
        vecs[0] = '{32'd5,        32'd5,        1'b1, 32'd0,        1'b1, 32'd0,        4'b0110, 32'd0,        4'b0110, 1'b0};
        vecs[1] = '{32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFE, 4'b1000, 32'hFFFFFFFE, 4'b1000, 1'b0};
        vecs[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 32'h23456789, 4'b0000, 32'h23456789, 4'b0000, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 32'h80000000, 4'b1001, 32'h7FFFFFFF, 4'b0001, 1'b1};
        vecs[4] = '{32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 4'b0011, 32'h80000000, 4'b1011, 1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        1'b1, 32'd0,        4'b0110, 32'd0,        4'b0110, 1'b1};
        vecs[6] = '{32'h80000000, 32'h80000000, 1'b0, 32'd0,        1'b1, 32'd0,        4'b0111, 32'h80000000, 4'b1011, 1'b1};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        clr_sticky = 1'b0;
        drive_op(32'd0, 32'd0, 1'b0, 32'd0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready0, 0);
        check("rst out_valid", out_valid0, 0);
        check("rst out_result", out_result0, 0);
        check("rst out_flags", out_flags0, 0);
        check("rst sticky", sticky0, 0);
        check("rst op_count", op_count0, 0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", in_ready0, 1);

        // Table-driven flag / saturation vectors, one entry at a time
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].cout);
            in_valid  = 1'b1;
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), out_valid0, 1);
            check($sformatf("vec%0d result sat0", i), out_result0, vecs[i].res0);
            check($sformatf("vec%0d flags sat0", i), out_flags0, vecs[i].fl0);
            check($sformatf("vec%0d result sat1", i), out_result1, vecs[i].res1);
            check($sformatf("vec%0d flags sat1", i), out_flags1, vecs[i].fl1);
            check($sformatf("vec%0d sticky", i), sticky0, vecs[i].sticky);
            check($sformatf("vec%0d op_count", i), op_count0, 32'(i + 1));
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d empty after pop", i), out_valid0, 0);
            check($sformatf("vec%0d hold when empty", i), out_result0, vecs[i].res0);
        end

        // Fill DEPTH=2 buffer with out_ready low; third entry must wait
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_op(32'd0, 32'd1, 1'b0, 32'd1, 1'b0);
        @(posedge clk);
        #1;
        check("fifo in_ready after 1", in_ready0, 1);
        check("fifo head after 1", out_result0, 1);
        @(negedge clk);
        drive_op(32'd0, 32'd2, 1'b0, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        check("fifo in_ready full", in_ready0, 0);
        check("fifo head after 2", out_result0, 1);
        check("fifo op_count 9", op_count0, 9);
        @(negedge clk);
        drive_op(32'd0, 32'd3, 1'b0, 32'd3, 1'b0);
        @(posedge clk);
        #1;
        check("fifo stall in_ready", in_ready0, 0);
        check("fifo stall head", out_result0, 1);
        check("fifo stall op_count", op_count0, 9);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("fifo pop1 head", out_result0, 2);
        check("fifo pop1 in_ready", in_ready0, 1);
        check("fifo pop1 valid", out_valid0, 1);
        @(posedge clk);
        #1;
        check("fifo pop2 head", out_result0, 3);
        check("fifo push3 op_count", op_count0, 10);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("fifo drained", out_valid0, 0);
        check("fifo drained hold", out_result0, 3);

        // Sticky overflow: clear alone, set+clear together, clear alone
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        check("sticky clear", sticky0, 0);
        @(negedge clk);
        drive_op(32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("sticky set wins", sticky0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sticky clear again", sticky0, 0);
        @(negedge clk);
        clr_sticky = 1'b0;

        // Two entries buffered, then asynchronous reset mid-cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_op(32'd0, 32'h11, 1'b0, 32'h11, 1'b0);
        @(negedge clk);
        drive_op(32'd0, 32'h22, 1'b0, 32'h22, 1'b0);
        @(posedge clk);
        #1;
        check("pre-rst buffer full", in_ready0, 0);
        #1;
        rst = 1'b1;
        #1;
        check("async rst out_valid", out_valid0, 0);
        check("async rst in_ready", in_ready0, 0);
        check("async rst out_result", out_result0, 0);
        check("async rst op_count", op_count0, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        drive_op(32'd0, 32'h55, 1'b0, 32'h55, 1'b0);
        #1;
        check("rst release in_ready", in_ready0, 1);
        check("rst release out_valid", out_valid0, 0);
        @(posedge clk);
        #1;
        check("first after rst valid", out_valid0, 1);
        check("first after rst result", out_result0, 32'h55);
        check("first after rst op_count", op_count0, 1);

        // Continuous accept/pop until op_count has seen 65536 accepts
        repeat (65535) @(posedge clk);
        #1;
        check("op_count wrap", op_count0, 0);
        check("op_count wrap sat1", op_count1, 0);
        @(negedge clk);
        in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
- Downstream consumer of the 32-bit combinational adder/subtractor.
- Each cycle it captures the adder's sum and carry-out together with the operands that produced them.
- It computes N/Z/C/V flags, optionally saturates on signed overflow, and presents results through a small valid/ready output buffer.
- It keeps a sticky overflow flag and an accepted-operation counter for the surrounding datapath.

Parameters:
- DEPTH, 2, number of output buffer entries; must be a power of two and at least 2.
- SAT, 0, when 1, a signed overflow clamps the result to the signed extreme.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  adder result and operands are valid.
- in_ready  out  1  stage can accept an entry.
- in_a  in  32  adder operand a.
- in_b  in  32  adder operand b, before sub inversion.
- in_sub  in  1  1 = operation was a - b.
- in_sum  in  32  adder sum.
- in_cout  in  1  adder carry-out of bit 31.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_result  out  32  head result, saturated if SAT=1.
- out_flags  out  4  {N,Z,C,V} of the head entry.
- sticky_v  out  1  set by any accepted overflow.
- clr_sticky  in  1  clears sticky_v.
- op_count  out  16  number of accepted entries, wraps.

Behaviour:
- Reset (async assert, sync release):
  - buffer count and pointers = 0, out_valid = 0, out_result = 0, out_flags = 0, sticky_v = 0, op_count = 0.
  - in_ready = 0 while rst is high.
- Effective operand: beff = in_b XOR {32{in_sub}}.
- V = (in_a[31] == beff[31]) AND (in_sum[31] != in_a[31]).
- C = in_cout for both add and subtract. For subtract, C = 1 means no borrow.
- Saturation, SAT=1 with V=1: result = 0x8000_0000 if in_a[31] = 1, else 0x7FFF_FFFF. Otherwise result = in_sum.
- N = result[31] and Z = (result == 0), both from the final result. C and V are always the raw values.
- Accept: in_valid AND in_ready. in_ready = (count != DEPTH). in_ready is registered-state based and does not depend on out_ready.
- Pop: out_valid AND out_ready. out_valid = (count != 0).
- Latency: an entry accepted at edge k drives out_valid/out_result/out_flags immediately after edge k when the buffer was empty.
- Ordering is strict FIFO. The head outputs hold stable while out_valid=1 and out_ready=0.
- Push and pop in the same cycle (0 < count < DEPTH): count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Full: in_ready = 0, so no push can occur; a pop frees one slot for the next cycle.
- Empty: a pop is ignored; out_result/out_flags hold their last value.
- sticky_v:
  - set on accept when V=1;
  - cleared on clr_sticky;
  - if set and clear occur in the same cycle, set wins.
- op_count: +1 per accept, 0xFFFF wraps to 0x0000.
- Reset mid-operation: all buffered entries are discarded immediately. No partial output after rst is released.

Decomposition:
- Shared package holds:
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - SAT_MAX=0x7FFF_FFFF and SAT_MIN=0x8000_0000;
  - a flags typedef of 4 bits.
- One combinational sub-module, addsub_flag_calc: inputs a, b, sub, sum, cout; outputs result and flags. The buffer and counters stay in addsub_result_stage.

Test Plan:
- SAT=0; a=0x7FFF_FFFF, b=1, sub=0, sum=0x8000_0000, cout=0 -> out_result=0x8000_0000, flags N1 Z0 C0 V1, sticky_v=1, op_count=1.
- SAT=1, same stimulus -> out_result=0x7FFF_FFFF, flags N0 Z0 C0 V1. Then a=0x8000_0000, b=1, sub=1, sum=0x7FFF_FFFF, cout=1 -> result 0x8000_0000, N1 Z0 C1 V1.
- a=5, b=5, sub=1, sum=0, cout=1 -> result 0, flags N0 Z1 C1 V0, sticky_v unchanged.
- DEPTH=2, out_ready=0, drive three valid entries (sums 1, 2, 3):
  - in_ready drops after two accepts and entry 3 waits; out_result stays at 1.
  - set out_ready=1 -> outputs 1, 2, 3 in order, with in_ready high again after the first pop.
- clr_sticky=1 in the same cycle as an accepted V=1 entry -> sticky_v stays 1. Then clr_sticky alone -> 0. Apply 65536 accepts -> op_count returns to 0x0000.
- Buffer holding 2 entries, assert rst mid-cycle -> out_valid=0 and count=0 without waiting for a clock edge. After release, in_ready=1 and the first new entry appears after one edge.
